// File: rtl/ram_sp_be_arb_pkg.sv
// Shared definitions for the bit-enable RAM arbiter: RAM geometry and response FIFO depth.
package ram_sp_be_arb_pkg;

   localparam int ENC_ADR_WD     = 8;
   localparam int ENC_DAT_WD     = 128;
   localparam int ENC_DEPTH      = 192;
   localparam int ENC_FIFO_DEPTH = 3;
   localparam int ENC_FIFO_CNT_WD = 2;

endpackage

// File: rtl/ram_sp_be_arb_rsp_fifo.sv
// Three-entry in-order read response FIFO; entry 0 is the output register,
// so rsp data comes straight from a flop and holds while not popped.
module rsp_fifo_3x128
   import ram_sp_be_arb_pkg::*;
#(
   parameter int DAT_WD = ENC_DAT_WD
) (
   input  logic                       clk,
   input  logic                       rstn,
   input  logic                       i_push,
   input  logic [DAT_WD-1:0]          i_push_dat,
   input  logic                       i_pop_rdy,
   output logic                       o_vld,
   output logic [DAT_WD-1:0]          o_dat,
   output logic [ENC_FIFO_CNT_WD-1:0] o_cnt
);

   localparam logic [ENC_FIFO_CNT_WD-1:0] LP_FULL = ENC_FIFO_CNT_WD'(ENC_FIFO_DEPTH);

   logic [DAT_WD-1:0]          r_mem [ENC_FIFO_DEPTH];
   logic [ENC_FIFO_CNT_WD-1:0] r_cnt;
   logic                       w_pop;
   logic                       w_push;
   logic [ENC_FIFO_CNT_WD-1:0] w_wr_idx;

   assign w_pop    = i_pop_rdy && (r_cnt != '0);
   assign w_push   = i_push && ((r_cnt != LP_FULL) || w_pop);
   assign w_wr_idx = w_pop ? (r_cnt - 1'b1) : r_cnt;

   // Pop shifts everything toward entry 0; a simultaneous push lands behind the shift.
   always_ff @(posedge clk) begin
      if (!rstn) begin
         for (int i = 0; i < ENC_FIFO_DEPTH; i++) r_mem[i] <= '0;
         r_cnt <= '0;
      end else begin
         if (w_pop) begin
            for (int i = 0; i < ENC_FIFO_DEPTH - 1; i++) r_mem[i] <= r_mem[i+1];
            r_mem[ENC_FIFO_DEPTH-1] <= '0;
         end
         if (w_push) r_mem[w_wr_idx] <= i_push_dat;
         case ({w_push, w_pop})
            2'b10:   r_cnt <= r_cnt + 1'b1;
            2'b01:   r_cnt <= r_cnt - 1'b1;
            default: r_cnt <= r_cnt;
         endcase
      end
   end

   assign o_vld = (r_cnt != '0);
   assign o_dat = r_mem[0];
   assign o_cnt = r_cnt;

endmodule

// File: rtl/ram_sp_be_arb.sv
// Round-robin read/write arbiter in front of a single-port bit-enable RAM,
// with a credit-limited in-order read response FIFO.
module ram_sp_be_arb
   import ram_sp_be_arb_pkg::*;
#(
   parameter int ADR_WD = ENC_ADR_WD,
   parameter int DAT_WD = ENC_DAT_WD,
   parameter int DEPTH  = ENC_DEPTH
) (
   input  logic              clk,
   input  logic              rstn,
   input  logic              wr_val_i,
   output logic              wr_rdy_o,
   input  logic [ADR_WD-1:0] wr_adr_i,
   input  logic [DAT_WD-1:0] wr_msk_i,
   input  logic [DAT_WD-1:0] wr_dat_i,
   input  logic              rd_val_i,
   output logic              rd_rdy_o,
   input  logic [ADR_WD-1:0] rd_adr_i,
   output logic              rsp_vld_o,
   input  logic              rsp_rdy_i,
   output logic [DAT_WD-1:0] rsp_dat_o,
   output logic              err_o,
   output logic [ADR_WD-1:0] ram_adr_o,
   output logic [DAT_WD-1:0] ram_wr_ena_o,
   output logic [DAT_WD-1:0] ram_wr_dat_o,
   output logic              ram_rd_ena_o,
   input  logic [DAT_WD-1:0] ram_rd_dat_i
);

   localparam logic [ADR_WD:0] LP_DEPTH = (ADR_WD+1)'(DEPTH);
   localparam logic [2:0]      LP_OCC_MAX = 3'(ENC_FIFO_DEPTH);

   logic                       r_prio_wr;
   logic                       r_inflight;
   logic                       r_inflight_oor;
   logic                       r_err;
   logic [ENC_FIFO_CNT_WD-1:0] w_fifo_cnt;
   logic [2:0]                 w_occ;
   logic                       w_wr_elig;
   logic                       w_rd_elig;
   logic                       w_gnt_wr;
   logic                       w_gnt_rd;
   logic                       w_wr_inr;
   logic                       w_rd_inr;
   logic [DAT_WD-1:0]          w_push_dat;

   // Occupancy counts the read in flight so a granted read always has a FIFO slot.
   assign w_occ     = {1'b0, w_fifo_cnt} + {2'b00, r_inflight};
   assign w_wr_elig = rstn && wr_val_i;
   assign w_rd_elig = rstn && rd_val_i && (w_occ < LP_OCC_MAX);
   assign w_gnt_wr  = w_wr_elig && (!w_rd_elig || r_prio_wr);
   assign w_gnt_rd  = w_rd_elig && (!w_wr_elig || !r_prio_wr);
   assign w_wr_inr  = ({1'b0, wr_adr_i} < LP_DEPTH);
   assign w_rd_inr  = ({1'b0, rd_adr_i} < LP_DEPTH);

   assign wr_rdy_o = w_gnt_wr;
   assign rd_rdy_o = w_gnt_rd;
   assign err_o    = r_err;

   always_comb begin
      ram_adr_o    = '0;
      ram_wr_ena_o = '0;
      ram_wr_dat_o = '0;
      ram_rd_ena_o = 1'b0;
      if (w_gnt_wr && w_wr_inr) begin
         ram_adr_o    = wr_adr_i;
         ram_wr_ena_o = wr_msk_i;
         ram_wr_dat_o = wr_dat_i;
      end else if (w_gnt_rd && w_rd_inr) begin
         ram_adr_o    = rd_adr_i;
         ram_rd_ena_o = 1'b1;
      end
   end

   // Out-of-range reads still occupy a slot and return zeros in order.
   always_ff @(posedge clk) begin
      if (!rstn) begin
         r_prio_wr      <= 1'b1;
         r_inflight     <= 1'b0;
         r_inflight_oor <= 1'b0;
         r_err          <= 1'b0;
      end else begin
         if (w_wr_elig && w_rd_elig) r_prio_wr <= w_gnt_rd;
         r_inflight     <= w_gnt_rd;
         r_inflight_oor <= w_gnt_rd && !w_rd_inr;
         r_err          <= (w_gnt_wr && !w_wr_inr) || (w_gnt_rd && !w_rd_inr);
      end
   end

   assign w_push_dat = r_inflight_oor ? '0 : ram_rd_dat_i;

   rsp_fifo_3x128 #(
      .DAT_WD (DAT_WD)
   ) u_rsp_fifo (
      .clk        (clk),
      .rstn       (rstn),
      .i_push     (r_inflight),
      .i_push_dat (w_push_dat),
      .i_pop_rdy  (rsp_rdy_i),
      .o_vld      (rsp_vld_o),
      .o_dat      (rsp_dat_o),
      .o_cnt      (w_fifo_cnt)
   );

endmodule

// File: tb/tb_ram_sp_be_arb.sv
// Directed and randomized bench for ram_sp_be_arb against a transaction-level
// model: a word array plus a queue of outstanding read responses.
module tb_ram_sp_be_arb;

   localparam int AW    = 8;
   localparam int DW    = 128;
   localparam int DEPTH = 192;

   logic          clk = 1'b0;
   logic          rstn = 1'b0;
   logic          wr_val_i = 1'b0;
   logic          wr_rdy_o;
   logic [AW-1:0] wr_adr_i = '0;
   logic [DW-1:0] wr_msk_i = '0;
   logic [DW-1:0] wr_dat_i = '0;
   logic          rd_val_i = 1'b0;
   logic          rd_rdy_o;
   logic [AW-1:0] rd_adr_i = '0;
   logic          rsp_vld_o;
   logic          rsp_rdy_i = 1'b0;
   logic [DW-1:0] rsp_dat_o;
   logic          err_o;
   logic [AW-1:0] ram_adr_o;
   logic [DW-1:0] ram_wr_ena_o;
   logic [DW-1:0] ram_wr_dat_o;
   logic          ram_rd_ena_o;
   logic [DW-1:0] ram_rd_dat_i;

   always #5 clk = ~clk;

   ram_sp_be_arb #(.ADR_WD(AW), .DAT_WD(DW), .DEPTH(DEPTH)) dut (
      .clk          (clk),
      .rstn         (rstn),
      .wr_val_i     (wr_val_i),
      .wr_rdy_o     (wr_rdy_o),
      .wr_adr_i     (wr_adr_i),
      .wr_msk_i     (wr_msk_i),
      .wr_dat_i     (wr_dat_i),
      .rd_val_i     (rd_val_i),
      .rd_rdy_o     (rd_rdy_o),
      .rd_adr_i     (rd_adr_i),
      .rsp_vld_o    (rsp_vld_o),
      .rsp_rdy_i    (rsp_rdy_i),
      .rsp_dat_o    (rsp_dat_o),
      .err_o        (err_o),
      .ram_adr_o    (ram_adr_o),
      .ram_wr_ena_o (ram_wr_ena_o),
      .ram_wr_dat_o (ram_wr_dat_o),
      .ram_rd_ena_o (ram_rd_ena_o),
      .ram_rd_dat_i (ram_rd_dat_i)
   );

   // Physical RAM attached to the DUT ports: one-cycle read latency, bitwise write enable.
   logic [DW-1:0] ram_mem [256] = '{default: '0};
   logic [DW-1:0] ram_q = '0;
   int            ram_oor_hits = 0;

   always @(posedge clk) begin
      if (ram_rd_ena_o) ram_q <= ram_mem[ram_adr_o];
      if (ram_wr_ena_o != '0)
         ram_mem[ram_adr_o] <= (ram_mem[ram_adr_o] & ~ram_wr_ena_o) | (ram_wr_dat_o & ram_wr_ena_o);
      if ((ram_rd_ena_o || (ram_wr_ena_o != '0)) && (int'(ram_adr_o) >= DEPTH))
         ram_oor_hits <= ram_oor_hits + 1;
   end
   assign ram_rd_dat_i = ram_q;

   // Reference model
   typedef struct {
      logic [DW-1:0] dat;
      int            rc;
   } rsp_t;

   logic [DW-1:0] ref_mem [DEPTH];
   rsp_t          exp_q[$];
   logic          prio_wr;
   logic          err_prev;
   int            cyc;
   int            checks;
   int            errors;

   task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic step(input logic wv, input logic [AW-1:0] wa, input logic [DW-1:0] wm,
                       input logic [DW-1:0] wd, input logic rv, input logic [AW-1:0] ra,
                       input logic rr, output logic ow, output logic orr);
      logic gw, gr, rd_ok, w_in, r_in, e_vld, e_rena;
      logic [DW-1:0] e_adr, e_wena, e_wdat;
      rsp_t r;
      wr_val_i = wv; wr_adr_i = wa; wr_msk_i = wm; wr_dat_i = wd;
      rd_val_i = rv; rd_adr_i = ra; rsp_rdy_i = rr;
      #1;
      rd_ok = rv && (exp_q.size() < 3);
      gw    = wv && (!rd_ok || prio_wr);
      gr    = rd_ok && (!wv || !prio_wr);
      w_in  = int'(wa) < DEPTH;
      r_in  = int'(ra) < DEPTH;
      e_vld = (exp_q.size() > 0) && (exp_q[0].rc <= cyc);
      ow  = wr_rdy_o;
      orr = rd_rdy_o;
      chk("wr_rdy", wr_rdy_o, gw);
      chk("rd_rdy", rd_rdy_o, gr);
      chk("err", err_o, err_prev);
      chk("rsp_vld", rsp_vld_o, e_vld);
      if (e_vld) chk("rsp_dat", rsp_dat_o, exp_q[0].dat);
      e_adr = '0; e_wena = '0; e_wdat = '0; e_rena = 1'b0;
      if (gw && w_in) begin
         e_adr = DW'(wa); e_wena = wm; e_wdat = wd;
      end else if (gr && r_in) begin
         e_adr = DW'(ra); e_rena = 1'b1;
      end
      chk("ram_adr", ram_adr_o, e_adr);
      chk("ram_wr_ena", ram_wr_ena_o, e_wena);
      chk("ram_rd_ena", ram_rd_ena_o, e_rena);
      if (!(gr && r_in)) chk("ram_wr_dat", ram_wr_dat_o, e_wdat);
      chk("one_ena", ram_rd_ena_o && (ram_wr_ena_o != '0), 1'b0);
      @(posedge clk);
      if (gw && w_in) ref_mem[wa] = (ref_mem[wa] & ~wm) | (wd & wm);
      if (e_vld && rr) void'(exp_q.pop_front());
      if (gr) begin
         r.dat = r_in ? ref_mem[ra] : '0;
         r.rc  = cyc + 2;
         exp_q.push_back(r);
      end
      if (wv && rd_ok) prio_wr = gr;
      err_prev = (gw && !w_in) || (gr && !r_in);
      cyc++;
      #1;
   endtask

   task automatic idle(input logic rr);
      logic a, b;
      step(1'b0, '0, '0, '0, 1'b0, '0, rr, a, b);
   endtask

   task automatic do_reset();
      rstn = 1'b0;
      wr_val_i = 1'b1; wr_adr_i = 8'd3; wr_msk_i = '1; wr_dat_i = '1;
      rd_val_i = 1'b1; rd_adr_i = 8'd4; rsp_rdy_i = 1'b0;
      #1;
      chk("rst_wr_rdy", wr_rdy_o, 1'b0);
      chk("rst_rd_rdy", rd_rdy_o, 1'b0);
      chk("rst_wr_ena", ram_wr_ena_o, '0);
      chk("rst_rd_ena", ram_rd_ena_o, 1'b0);
      @(posedge clk);
      #1;
      chk("rst_vld", rsp_vld_o, 1'b0);
      chk("rst_dat", rsp_dat_o, '0);
      chk("rst_err", err_o, 1'b0);
      rstn = 1'b1;
      wr_val_i = 1'b0; rd_val_i = 1'b0;
      exp_q.delete();
      prio_wr  = 1'b1;
      err_prev = 1'b0;
      cyc++;
   endtask

   initial begin
      logic [DW-1:0] pat_a5, ones, pat2, rmsk, rdat;
      logic ow, orr;
      logic [AW-1:0] wa, ra;
      int acc;
      checks = 0; errors = 0; cyc = 0; prio_wr = 1'b1; err_prev = 1'b0;
      for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
      pat_a5 = {16{8'hA5}};
      ones   = '1;

      do_reset();

      // Full-mask write then read back with two-cycle response latency
      step(1'b1, 8'd5, ones, pat_a5, 1'b0, '0, 1'b1, ow, orr);
      step(1'b0, '0, '0, '0, 1'b1, 8'd5, 1'b1, ow, orr);
      idle(1'b1);
      chk("s1_vld", rsp_vld_o, 1'b1);
      chk("s1_dat", rsp_dat_o, pat_a5);
      idle(1'b1);

      // Partial mask overwrites only the low byte
      step(1'b1, 8'd5, 128'hFF, ones, 1'b0, '0, 1'b1, ow, orr);
      step(1'b0, '0, '0, '0, 1'b1, 8'd5, 1'b1, ow, orr);
      idle(1'b1);
      pat2 = {pat_a5[DW-1:8], 8'hFF};
      chk("s2_dat", rsp_dat_o, pat2);
      idle(1'b1);

      // Contested requests alternate starting with the write
      do_reset();
      for (int i = 0; i < 4; i++) begin
         step(1'b1, 8'd10, ones, DW'(i), 1'b1, 8'd11, 1'b1, ow, orr);
         chk("s3_alt_w", ow, (i % 2) == 0);
         chk("s3_alt_r", orr, (i % 2) == 1);
      end
      repeat (3) idle(1'b1);

      // Stalled consumer: three reads accepted, writes still pass, responses in order
      acc = 0;
      for (int i = 0; i < 5; i++) begin
         step(i >= 3, AW'(20 + i), ones, DW'(i + 100), 1'b1, AW'(i), 1'b0, ow, orr);
         if (orr) acc++;
         if (i >= 3) chk("s4_wr_pass", ow, 1'b1);
      end
      chk("s4_acc", acc, 3);
      repeat (5) idle(1'b1);

      // Out-of-range read and write
      step(1'b0, '0, '0, '0, 1'b1, 8'd192, 1'b1, ow, orr);
      chk("s5_err_rd", err_o, 1'b1);
      step(1'b1, 8'd200, ones, ones, 1'b0, '0, 1'b1, ow, orr);
      chk("s5_err_wr", err_o, 1'b1);
      chk("s5_vld", rsp_vld_o, 1'b1);
      chk("s5_dat", rsp_dat_o, '0);
      idle(1'b1);
      chk("s5_err_end", err_o, 1'b0);
      chk("s5_ram_untouched", ram_oor_hits, 0);

      // Reset with responses queued discards them
      step(1'b0, '0, '0, '0, 1'b1, 8'd1, 1'b0, ow, orr);
      step(1'b0, '0, '0, '0, 1'b1, 8'd2, 1'b0, ow, orr);
      repeat (2) idle(1'b0);
      chk("s6_queued", rsp_vld_o, 1'b1);
      do_reset();
      repeat (5) idle(1'b1);

      // Randomized traffic
      for (int n = 0; n < 500; n++) begin
         wa   = ($urandom_range(0, 9) == 0) ? AW'($urandom_range(190, 200)) : AW'($urandom_range(0, 7));
         ra   = ($urandom_range(0, 9) == 0) ? AW'($urandom_range(190, 200)) : AW'($urandom_range(0, 7));
         rmsk = ($urandom_range(0, 7) == 0) ? '0 : {$urandom, $urandom, $urandom, $urandom};
         rdat = {$urandom, $urandom, $urandom, $urandom};
         step(1'($urandom_range(0, 1)), wa, rmsk, rdat, 1'($urandom_range(0, 1)), ra,
              $urandom_range(0, 3) != 0, ow, orr);
      end
      repeat (8) idle(1'b1);
      chk("end_ram_untouched", ram_oor_hits, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
